// File: rtl/store_seq_ctrl_if.sv
// Store sequencer bus bundle: the execute-side request channel plus the
// data-memory beat channel and the completion pulses.
interface store_seq_ctrl_if;
    // Request from execute
    logic        req_valid;
    logic        req_ready;
    logic [31:0] instr;
    logic [31:0] daddr;
    logic [31:0] wdata;

    // Beat towards data memory
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;

    // Completion
    logic        done;
    logic        err;

    // Controller side
    modport master (
        input  req_valid, instr, daddr, wdata, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
    );

    // Environment side (execute stage + memory)
    modport slave (
        output req_valid, instr, daddr, wdata, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we, done, err
    );
endinterface

// File: rtl/store_seq_ctrl.sv
// RV32I store sequencer: takes one SB/SH/SW at a time, builds byte-lane
// enables and lane-aligned data, and splits word-crossing stores into two
// aligned beats. Completion is a one-cycle done/err pulse.
module store_seq_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    store_seq_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Beat-1 payload, prepared at capture so the second beat needs no
    // recomputation once the request inputs are gone.
    logic [31:0] beat1_addr_q;
    logic [31:0] beat1_data_q;
    logic [3:0]  beat1_we_q;

    // Registered port outputs and their next values
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_we_q,    mem_we_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;

    // Request decode
    logic [2:0]  funct3;
    logic        legal;
    logic [1:0]  off;
    logic [31:0] base;
    logic [3:0]  base_mask;
    logic [7:0]  m8;
    logic [63:0] d64;
    logic        capture;

    // Only funct3 is meaningful; the rest of the instruction word is ignored.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:0]};

    assign funct3  = bus.instr[14:12];
    assign off     = bus.daddr[1:0];
    assign base    = {bus.daddr[31:2], 2'b00};
    assign capture = (state_q == IDLE) && bus.req_valid;

    // Width decode: base lane mask per funct3, illegal encodings flagged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned, which would infer a latch.
        base_mask = 4'b0000;
        legal     = 1'b1;
        case (funct3)
            3'b000:  base_mask = 4'b0001;
            3'b001:  base_mask = 4'b0011;
            3'b010:  base_mask = 4'b1111;
            default: legal     = 1'b0;
        endcase
    end

    // Low nibble of m8 / low word of d64 form beat 0, the high halves beat 1.
    assign m8  = {4'b0000, base_mask} << off;
    assign d64 = {32'h0, bus.wdata} << {off, 3'b000};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a beat only advances when memory accepts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (capture)       state_d = legal ? BEAT0 : RESP;
            BEAT0: if (bus.mem_ready) state_d = (|beat1_we_q) ? BEAT1 : RESP;
            BEAT1: if (bus.mem_ready) state_d = RESP;
            RESP:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; hold the beat while stalled.
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                mem_valid_d = 1'b0;
                mem_addr_d  = 32'h0;
                mem_wdata_d = 32'h0;
                mem_we_d    = 4'b0000;
                if (capture && legal) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = base;
                    mem_wdata_d = d64[31:0];
                    mem_we_d    = m8[3:0];
                end else if (capture) begin
                    err_d = 1'b1;
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (|beat1_we_q) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = beat1_addr_q;
                        mem_wdata_d = beat1_data_q;
                        mem_we_d    = beat1_we_q;
                    end else begin
                        mem_valid_d = 1'b0;
                        mem_addr_d  = 32'h0;
                        mem_wdata_d = 32'h0;
                        mem_we_d    = 4'b0000;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_we_d    = 4'b0000;
                    done_d      = 1'b1;
                end
            end
            default: begin
                mem_valid_d = 1'b0;
                mem_addr_d  = 32'h0;
                mem_wdata_d = 32'h0;
                mem_we_d    = 4'b0000;
            end
        endcase
    end

    // Output registers; reset drops any pending beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 4'b0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Beat-1 payload capture; base + 4 wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat1_addr_q <= 32'h0;
            beat1_data_q <= 32'h0;
            beat1_we_q   <= 4'b0000;
        end else if (capture) begin
            beat1_addr_q <= base + 32'd4;
            beat1_data_q <= d64[63:32];
            beat1_we_q   <= legal ? m8[7:4] : 4'b0000;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Directed bench for store_seq_ctrl: a table of store vectors with
// hand-computed beats, plus a hand-written reset-during-stall sequence.
module tb_store_seq_ctrl;

    logic clk;
    logic rst_n;

    store_seq_ctrl_if bus ();

    store_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] daddr;
        logic [31:0] wdata;
        int          beats;   // 0 = illegal funct3
        logic [31:0] a0;
        logic [3:0]  w0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  w1;
        logic [31:0] d1;
        int          stall0;
        int          stall1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one beat held for stall+1 cycles, releasing mem_ready on the last.
    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d, input int stall);
        for (int k = 0; k <= stall; k++) begin
            bus.mem_ready = (k == stall);
            check({tag, "/valid"}, {31'h0, bus.mem_valid}, 32'h1);
            check({tag, "/addr"},  bus.mem_addr,  a);
            check({tag, "/we"},    {28'h0, bus.mem_we}, {28'h0, w});
            check({tag, "/data"},  bus.mem_wdata, d);
            check({tag, "/rdy"},   {31'h0, bus.req_ready}, 32'h0);
            check({tag, "/done"},  {31'h0, bus.done}, 32'h0);
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    // Issues one request from IDLE and checks the full response cycle by cycle.
    // req_valid stays high (with junk inputs) until done/err to show it is
    // ignored outside IDLE.
    task automatic run_vec(input vec_t v);
        check({v.name, "/idle_rdy"}, {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.instr     = 32'h0000_0023 | {17'h0, v.f3, 12'h0};
        bus.daddr     = v.daddr;
        bus.wdata     = v.wdata;
        bus.mem_ready = 1'b0;
        tick();
        bus.instr = 32'hFFFF_FFFF;
        bus.daddr = 32'h5555_5555;
        bus.wdata = 32'hA5A5_A5A5;
        if (v.beats == 0) begin
            check({v.name, "/err"},   {31'h0, bus.err},       32'h1);
            check({v.name, "/done"},  {31'h0, bus.done},      32'h0);
            check({v.name, "/valid"}, {31'h0, bus.mem_valid}, 32'h0);
            check({v.name, "/rdy"},   {31'h0, bus.req_ready}, 32'h0);
            bus.req_valid = 1'b0;
            tick();
            check({v.name, "/err_end"}, {31'h0, bus.err},       32'h0);
            check({v.name, "/valid2"},  {31'h0, bus.mem_valid}, 32'h0);
            check({v.name, "/rdy_end"}, {31'h0, bus.req_ready}, 32'h1);
        end else begin
            check_beat({v.name, "/b0"}, v.a0, v.w0, v.d0, v.stall0);
            if (v.beats == 2) check_beat({v.name, "/b1"}, v.a1, v.w1, v.d1, v.stall1);
            check({v.name, "/done"},  {31'h0, bus.done},      32'h1);
            check({v.name, "/err"},   {31'h0, bus.err},       32'h0);
            check({v.name, "/valid"}, {31'h0, bus.mem_valid}, 32'h0);
            check({v.name, "/we0"},   {28'h0, bus.mem_we},    32'h0);
            check({v.name, "/rdy"},   {31'h0, bus.req_ready}, 32'h0);
            bus.req_valid = 1'b0;
            tick();
            check({v.name, "/done_end"}, {31'h0, bus.done},      32'h0);
            check({v.name, "/rdy_end"},  {31'h0, bus.req_ready}, 32'h1);
        end
    endtask

    initial begin
        vecs[0] = '{"sb_off1",    3'b000, 32'h0000_0001, 32'h0000_00AB, 1,
                    32'h0000_0000, 4'b0010, 32'h0000_AB00, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[1] = '{"sw_aligned", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1,
                    32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[2] = '{"sw_off3",    3'b010, 32'h0000_0103, 32'h1122_3344, 2,
                    32'h0000_0100, 4'b1000, 32'h4400_0000,
                    32'h0000_0104, 4'b0111, 32'h0011_2233, 0, 0};
        vecs[3] = '{"sh_wrap",    3'b001, 32'hFFFF_FFFF, 32'h0000_CAFE, 2,
                    32'hFFFF_FFFC, 4'b1000, 32'hFE00_0000,
                    32'h0000_0000, 4'b0001, 32'h0000_00CA, 3, 0};
        vecs[4] = '{"sh_off2",    3'b001, 32'h0000_0202, 32'h1234_ABCD, 1,
                    32'h0000_0200, 4'b1100, 32'hABCD_0000, 32'h0, 4'h0, 32'h0, 1, 0};
        vecs[5] = '{"sb_off3",    3'b000, 32'h0000_0007, 32'h0000_00FF, 1,
                    32'h0000_0004, 4'b1000, 32'hFF00_0000, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[6] = '{"sw_off2",    3'b010, 32'h0000_0002, 32'hAABB_CCDD, 2,
                    32'h0000_0000, 4'b1100, 32'hCCDD_0000,
                    32'h0000_0004, 4'b0011, 32'h0000_AABB, 0, 2};
        vecs[7] = '{"ill_011",    3'b011, 32'h0000_0040, 32'h1234_5678, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[8] = '{"ill_111",    3'b111, 32'h0000_0041, 32'h8765_4321, 0,
                    32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[9] = '{"sh_off1",    3'b001, 32'h0000_0001, 32'h0000_BEEF, 1,
                    32'h0000_0000, 4'b0110, 32'h00BE_EF00, 32'h0, 4'h0, 32'h0, 0, 0};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.instr     = 32'h0;
        bus.daddr     = 32'h0;
        bus.wdata     = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset state
        #2;
        check("rst/rdy",   {31'h0, bus.req_ready}, 32'h1);
        check("rst/valid", {31'h0, bus.mem_valid}, 32'h0);
        check("rst/we",    {28'h0, bus.mem_we},    32'h0);
        check("rst/addr",  bus.mem_addr,           32'h0);
        check("rst/data",  bus.mem_wdata,          32'h0);
        check("rst/done",  {31'h0, bus.done},      32'h0);
        check("rst/err",   {31'h0, bus.err},       32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during a stalled beat 1
        bus.req_valid = 1'b1;
        bus.instr     = 32'h0000_2023;
        bus.daddr     = 32'h0000_0103;
        bus.wdata     = 32'h1122_3344;
        tick();
        bus.req_valid = 1'b0;
        check_beat("rst_mid/b0", 32'h0000_0100, 4'b1000, 32'h4400_0000, 0);
        check("rst_mid/b1_valid", {31'h0, bus.mem_valid}, 32'h1);
        check("rst_mid/b1_we",    {28'h0, bus.mem_we},    32'h7);
        tick();
        check("rst_mid/b1_hold",  {31'h0, bus.mem_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/valid", {31'h0, bus.mem_valid}, 32'h0);
        check("rst_mid/we",    {28'h0, bus.mem_we},    32'h0);
        check("rst_mid/rdy",   {31'h0, bus.req_ready}, 32'h1);
        check("rst_mid/done",  {31'h0, bus.done},      32'h0);
        tick();
        rst_n = 1'b1;
        check("rst_mid/done2", {31'h0, bus.done},      32'h0);
        tick();
        check("rst_mid/done3", {31'h0, bus.done},      32'h0);
        check("rst_mid/valid3",{31'h0, bus.mem_valid}, 32'h0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
